// File: rtl/input_debouncer.sv
// Synchronizes and debounces active-low push-buttons and active-high switches,
// emits press/release pulses and queues level-change events behind valid/ready.
module input_debouncer #(
    parameter int NUM_KEYS        = 2,
    parameter int NUM_SW          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_SW-1:0]   sw,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_SW-1:0]   sw_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [7:0]          evt_data,
    output logic                evt_overflow,
    input  logic                overflow_clr
);

    localparam int NUM_IN = NUM_KEYS + NUM_SW;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IN-1:0] sync_lvl;
    logic [NUM_IN-1:0] st_lvl;
    logic [NUM_IN-1:0] accept;
    logic [NUM_IN-1:0] pending_reg;
    logic [NUM_IN-1:0] pending_next;
    logic [NUM_IN-1:0] load_mask;
    logic              load;
    logic              new_ovf;
    logic              sel_is_sw;
    logic [5:0]        sel_grp_idx;
    int                sel_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_in
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic                 st_reg;

            // Key chains reset to "released" so coming out of reset never looks like a press.
            if (gi < NUM_KEYS) begin : g_key
                logic [SYNC_STAGES-1:0] chain_reg;
                always_ff @(posedge CLOCK_50 or negedge reset_n) begin
                    if (!reset_n)
                        chain_reg <= '1;
                    else
                        chain_reg <= {chain_reg[SYNC_STAGES-2:0], key_n[gi]};
                end
                assign sync_lvl[gi] = ~chain_reg[SYNC_STAGES-1];
            end else begin : g_sw
                logic [SYNC_STAGES-1:0] chain_reg;
                always_ff @(posedge CLOCK_50 or negedge reset_n) begin
                    if (!reset_n)
                        chain_reg <= '0;
                    else
                        chain_reg <= {chain_reg[SYNC_STAGES-2:0], sw[gi-NUM_KEYS]};
                end
                assign sync_lvl[gi] = chain_reg[SYNC_STAGES-1];
            end

            always_ff @(posedge CLOCK_50 or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                    st_reg  <= 1'b0;
                end else if (sync_lvl[gi] == st_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_MAX) begin
                    st_reg  <= sync_lvl[gi];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign st_lvl[gi] = st_reg;
            assign accept[gi] = (sync_lvl[gi] != st_reg) && (cnt_reg == CNT_MAX);
        end
    endgenerate

    assign key_down = st_lvl[NUM_KEYS-1:0];
    assign sw_state = st_lvl[NUM_IN-1:NUM_KEYS];

    // Descending scan leaves the lowest pending index selected: keys win over switches.
    always_comb begin
        sel_idx = 0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (pending_reg[i])
                sel_idx = i;
        end
        sel_is_sw    = (sel_idx >= NUM_KEYS);
        sel_grp_idx  = sel_is_sw ? 6'(sel_idx - NUM_KEYS) : 6'(sel_idx);
        load         = (|pending_reg) && (!evt_valid || evt_ready);
        load_mask    = load ? ({{(NUM_IN-1){1'b0}}, 1'b1} << sel_idx) : '0;
        new_ovf      = |(accept & pending_reg & ~load_mask);
        pending_next = (pending_reg & ~load_mask) | accept;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_press    <= '0;
            key_release  <= '0;
            pending_reg  <= '0;
            evt_valid    <= 1'b0;
            evt_data     <= '0;
            evt_overflow <= 1'b0;
        end else begin
            key_press    <= accept[NUM_KEYS-1:0] & sync_lvl[NUM_KEYS-1:0];
            key_release  <= accept[NUM_KEYS-1:0] & ~sync_lvl[NUM_KEYS-1:0];
            pending_reg  <= pending_next;
            evt_overflow <= new_ovf | (evt_overflow & ~overflow_clr);
            if (load) begin
                evt_data  <= {st_lvl[sel_idx], sel_is_sw, sel_grp_idx};
                evt_valid <= 1'b1;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: table-driven press/release, directed corner cases,
// and a randomized run against a set-based reference model.
module tb_input_debouncer;

    localparam int NK  = 2;
    localparam int NS  = 4;
    localparam int N   = NK + NS;
    localparam int SYN = 2;
    localparam int DEB = 8;
    localparam int HL  = SYN + DEB;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n  = 1'b0;
    logic [NK-1:0] key_n    = '1;
    logic [NS-1:0] sw       = '0;
    logic          evt_ready    = 1'b1;
    logic          overflow_clr = 1'b0;
    logic [NK-1:0] key_down, key_press, key_release;
    logic [NS-1:0] sw_state;
    logic          evt_valid, evt_overflow;
    logic [7:0]    evt_data;

    int n_cmp = 0;
    int n_bad = 0;

    input_debouncer #(
        .NUM_KEYS(NK), .NUM_SW(NS), .SYNC_STAGES(SYN),
        .DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(3)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .key_n(key_n), .sw(sw),
        .key_down(key_down), .sw_state(sw_state), .key_press(key_press),
        .key_release(key_release), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .evt_overflow(evt_overflow), .overflow_clr(overflow_clr)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: levels as a history of pin samples; events as a set of
    // unreported changes served lowest index first.
    logic          model_on = 1'b0;
    logic          m_hist [N][HL];
    logic [N-1:0]  m_st, m_flag;
    logic          m_valid, m_ovf;
    logic [7:0]    m_data;
    logic [NK-1:0] m_press, m_rel;

    task automatic model_reset();
        for (int i = 0; i < N; i++)
            for (int a = 0; a < HL; a++) m_hist[i][a] = 1'b0;
        m_st = '0; m_flag = '0; m_valid = 1'b0; m_ovf = 1'b0;
        m_data = '0; m_press = '0; m_rel = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] st_b, fl_b, chg;
        logic ld, newovf;
        int idx;
        st_b = m_st; fl_b = m_flag; chg = '0;
        for (int i = 0; i < N; i++) begin
            for (int a = HL - 1; a > 0; a--) m_hist[i][a] = m_hist[i][a-1];
            if (i < NK) m_hist[i][0] = ~key_n[i];
            else        m_hist[i][0] = sw[i-NK];
            // Accept when the last DEB synchronized samples all disagree with the stable level.
            chg[i] = 1'b1;
            for (int a = SYN; a < HL; a++)
                if (m_hist[i][a] == st_b[i]) chg[i] = 1'b0;
        end
        m_st    = st_b ^ chg;
        m_press = chg[NK-1:0] & m_st[NK-1:0];
        m_rel   = chg[NK-1:0] & ~m_st[NK-1:0];
        idx = 0;
        for (int i = N - 1; i >= 0; i--) if (fl_b[i]) idx = i;
        ld = (fl_b != '0) && (!m_valid || evt_ready);
        if (ld) begin
            m_data  = {st_b[idx], (idx >= NK), (idx >= NK) ? 6'(idx - NK) : 6'(idx)};
            m_valid = 1'b1;
        end else if (m_valid && evt_ready) begin
            m_valid = 1'b0;
        end
        newovf = 1'b0;
        for (int i = 0; i < N; i++)
            if (chg[i] && fl_b[i] && !(ld && idx == i)) newovf = 1'b1;
        m_flag = fl_b;
        if (ld) m_flag[idx] = 1'b0;
        m_flag = m_flag | chg;
        m_ovf  = newovf | (m_ovf & ~overflow_clr);
    endtask

    task automatic model_check();
        chk("rnd_key_down", key_down, m_st[NK-1:0]);
        chk("rnd_sw_state", sw_state, m_st[N-1:NK]);
        chk("rnd_key_press", key_press, m_press);
        chk("rnd_key_release", key_release, m_rel);
        chk("rnd_evt_valid", evt_valid, m_valid);
        chk("rnd_overflow", evt_overflow, m_ovf);
        if (m_valid) chk("rnd_evt_data", evt_data, m_data);
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        if (model_on) model_edge();
        #1;
        if (model_on) model_check();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [NK-1:0] key_n;
        logic [NK-1:0] kd;
        logic [NK-1:0] kp;
        logic [NK-1:0] kr;
        logic          v;
        logic [7:0]    d;
    } vec_t;

    vec_t tbl [24];

    initial begin
        int press_cnt, press_at, ev_cnt;
        logic [7:0] ev_data;

        // Clean press then clean release of key 0, one row per clock.
        for (int r = 0; r < 24; r++) begin
            int q;
            q = (r < 12) ? r : r - 12;
            tbl[r].key_n = (r < 12) ? 2'b10 : 2'b11;
            tbl[r].kd    = (r < 12) ? ((q >= 9) ? 2'b01 : 2'b00) : ((q >= 9) ? 2'b00 : 2'b01);
            tbl[r].kp    = (r < 12 && q == 9) ? 2'b01 : 2'b00;
            tbl[r].kr    = (r >= 12 && q == 9) ? 2'b01 : 2'b00;
            tbl[r].v     = (q == 10);
            tbl[r].d     = (r < 12) ? 8'h80 : 8'h00;
        end

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("rst_key_down", key_down, 0);
        chk("rst_sw_state", sw_state, 0);
        chk("rst_key_press", key_press, 0);
        chk("rst_key_release", key_release, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_data", evt_data, 0);
        chk("rst_overflow", evt_overflow, 0);
        reset_n = 1'b1;

        for (int r = 0; r < 24; r++) begin
            key_n = tbl[r].key_n;
            step();
            chk("tbl_key_down", key_down, tbl[r].kd);
            chk("tbl_key_press", key_press, tbl[r].kp);
            chk("tbl_key_release", key_release, tbl[r].kr);
            chk("tbl_evt_valid", evt_valid, tbl[r].v);
            if (tbl[r].v) chk("tbl_evt_data", evt_data, tbl[r].d);
        end

        // Bouncing key 1: only the final settled level is accepted.
        press_cnt = 0; press_at = -1; ev_cnt = 0; ev_data = 8'h00;
        for (int c = 0; c < 50; c++) begin
            key_n[1] = (c < 30) ? (((c / 3) % 2 == 0) ? 1'b0 : 1'b1) : 1'b0;
            step();
            if (key_press[1]) begin press_cnt++; press_at = c; end
            if (evt_valid) begin ev_cnt++; ev_data = evt_data; end
            if (key_release != 2'b00) chk("bounce_no_release", key_release, 0);
        end
        chk("bounce_press_count", press_cnt, 1);
        chk("bounce_press_cycle", press_at, 39);
        chk("bounce_event_count", ev_cnt, 1);
        chk("bounce_event_data", ev_data, 8'h81);

        // Two switches rising together are reported on consecutive handshakes.
        sw = 4'b0101;
        for (int c = 0; c < 13; c++) begin
            step();
            if (c == 8)  chk("simul_sw_before", sw_state, 4'b0000);
            if (c == 9)  chk("simul_sw_after", sw_state, 4'b0101);
            if (c == 10) begin chk("simul_valid0", evt_valid, 1); chk("simul_data0", evt_data, 8'hC0); end
            if (c == 11) begin chk("simul_valid1", evt_valid, 1); chk("simul_data1", evt_data, 8'hC2); end
            if (c == 12) chk("simul_idle", evt_valid, 0);
        end

        // Backpressure: data holds, a doubly-changed switch sets the overflow flag.
        evt_ready = 1'b0;
        key_n[0]  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c == 15) key_n[0] = 1'b1;
            if (c == 30) sw[1] = 1'b1;
            if (c == 45) sw[1] = 1'b0;
            step();
            if (c == 10) chk("bp_valid", evt_valid, 1);
            if (c >= 10) chk("bp_data_hold", evt_data, 8'h80);
            if (c == 53) chk("bp_ovf_before", evt_overflow, 0);
            if (c == 54) chk("bp_ovf_set", evt_overflow, 1);
        end
        evt_ready = 1'b1;
        step();
        chk("bp_deliver_valid", evt_valid, 1);
        chk("bp_deliver_release", evt_data, 8'h00);
        step();
        chk("bp_deliver_sw", evt_data, 8'h41);
        step();
        chk("bp_drained", evt_valid, 0);
        chk("bp_ovf_sticky", evt_overflow, 1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("bp_ovf_cleared", evt_overflow, 0);

        // Reset in the middle of counting a press.
        key_n = 2'b00;
        for (int c = 0; c < 7; c++) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_key_down", key_down, 0);
        chk("mid_rst_sw_state", sw_state, 0);
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_data", evt_data, 0);
        chk("mid_rst_overflow", evt_overflow, 0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            if (c == 8)  chk("mid_rst_kd_early", key_down, 2'b00);
            if (c == 9)  chk("mid_rst_kd_accept", key_down, 2'b11);
            if (c == 10) chk("mid_rst_ev0", evt_data, 8'h80);
            if (c == 11) chk("mid_rst_ev1", evt_data, 8'h81);
            if (c == 12) chk("mid_rst_ev2", evt_data, 8'hC0);
            if (c == 13) chk("mid_rst_ev3", evt_data, 8'hC2);
            if (c == 14) chk("mid_rst_idle", evt_valid, 0);
        end

        // Switch held high through reset comes back through the debouncer.
        key_n = 2'b11;
        sw    = 4'b1000;
        reset_n = 1'b0;
        #1;
        chk("sw_rst_state", sw_state, 0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c == 8)  chk("sw_rst_early", sw_state, 4'b0000);
            if (c == 9)  chk("sw_rst_rise", sw_state, 4'b1000);
            if (c == 10) begin chk("sw_rst_valid", evt_valid, 1); chk("sw_rst_data", evt_data, 8'hC3); end
            if (c == 11) begin chk("sw_rst_idle", evt_valid, 0); chk("sw_rst_no_key", key_down, 0); end
        end

        // Randomized run against the reference model.
        key_n = 2'b11;
        sw    = 4'b0000;
        do_reset();
        model_reset();
        model_on = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NK; i++) if ($urandom_range(0, 13) == 0) key_n[i] = ~key_n[i];
            for (int i = 0; i < NS; i++) if ($urandom_range(0, 13) == 0) sw[i] = ~sw[i];
            evt_ready    = ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 39) == 0);
            step();
        end
        evt_ready    = 1'b1;
        overflow_clr = 1'b0;
        repeat (30) step();
        model_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
